tone_sequencer: RTL

Playback controller for the Simon Says tone path. It stores the current colour pattern and plays it back by driving the tone generator's frequency input and the colour LEDs, one step at a time. Each step plays a timed tone followed by a timed silence, and all timing is derived from ticks_per_ms. It sits between the game FSM, which loads the pattern and issues start/stop, and tone_generator.

---
 rtl/tone_sequencer_if.sv | 38 +++
 rtl/tone_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: control, pattern-write and playback-output bundle between the game FSM and tone_sequencer; `define SEQ_LOOP_EN adds loop
interface tone_sequencer_if #(
    parameter int IDX_W = 5
);
    logic [15:0]      ticks_per_ms;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [1:0]       wr_color;
    logic [IDX_W:0]   seq_len;
    logic [15:0]      tone_ms;
    logic [15:0]      gap_ms;
    logic             start;
    logic             stop;
    logic             busy;
    logic             done;
    logic [9:0]       frequency;
    logic [3:0]       led;
    logic [IDX_W-1:0] cur_step;
`ifdef SEQ_LOOP_EN
    logic             loop;
`endif

    modport master (
`ifdef SEQ_LOOP_EN
        output loop,
`endif
        output ticks_per_ms, wr_en, wr_addr, wr_color, seq_len, tone_ms, gap_ms, start, stop,
        input  busy, done, frequency, led, cur_step
    );

    modport slave (
`ifdef SEQ_LOOP_EN
        input  loop,
`endif
        input  ticks_per_ms, wr_en, wr_addr, wr_color, seq_len, tone_ms, gap_ms, start, stop,
        output busy, done, frequency, led, cur_step
    );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays the stored colour pattern as timed tones and silences; `define SEQ_LOOP_EN adds the loop input for repeated playback
module tone_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int IDX_W   = 5
) (
    input logic             clk,
    input logic             rst_n,
    tone_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    state_t           state;
    logic [1:0]       mem [MAX_LEN];
    logic [IDX_W:0]   len, start_len;
    logic [15:0]      tone, gap, pre, ms, tpm;
    logic [IDX_W-1:0] cur_step, nxt;
    logic [1:0]       first_color;
    logic [9:0]       frequency;
    logic [3:0]       led;
    logic             busy, done, ms_tick, last, tone_end, gap_end, loop_on;

    function automatic logic [9:0] freq_of(input logic [1:0] c);
        return c == 2'd0 ? 10'd415 : c == 2'd1 ? 10'd310 : c == 2'd2 ? 10'd252 : 10'd209;
    endfunction

    function automatic logic [3:0] led_of(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

`ifdef SEQ_LOOP_EN
    assign loop_on = bus.loop;
`else
    assign loop_on = 1'b0;
`endif

    // Phase timing, step sequencing, and the first colour with a same-cycle write bypassed in
    always_comb begin
        tpm         = bus.ticks_per_ms == 16'd0 ? 16'd1 : bus.ticks_per_ms;
        ms_tick     = pre >= tpm - 16'd1;
        tone_end    = ms_tick && ms == tone - 16'd1;
        gap_end     = ms_tick && ms == gap - 16'd1;
        last        = {1'b0, cur_step} + (IDX_W+1)'(1) == len;
        nxt         = last ? '0 : cur_step + IDX_W'(1);
        start_len   = bus.seq_len > (IDX_W+1)'(MAX_LEN) ? (IDX_W+1)'(MAX_LEN) : bus.seq_len;
        first_color = bus.wr_en && bus.wr_addr == '0 ? bus.wr_color : mem[0];
    end

    // Pattern memory accepts writes only while idle so playback sees a stable pattern
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.wr_en) mem[bus.wr_addr] <= bus.wr_color;
    end

    // Playback FSM; stop overrides any phase expiry in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            frequency <= '0;
            led       <= '0;
            cur_step  <= '0;
            pre       <= '0;
            ms        <= '0;
            len       <= '0;
            tone      <= 16'd1;
            gap       <= '0;
        end else begin
            done <= 1'b0;
            pre  <= ms_tick ? 16'd0 : pre + 16'd1;
            ms   <= ms_tick ? ms + 16'd1 : ms;
            if (state != IDLE && bus.stop) begin
                state     <= IDLE;
                busy      <= 1'b0;
                frequency <= '0;
                led       <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        len  <= start_len;
                        tone <= bus.tone_ms == 16'd0 ? 16'd1 : bus.tone_ms;
                        gap  <= bus.gap_ms;
                        done <= start_len == '0;
                        if (start_len != '0) begin
                            state     <= TONE;
                            busy      <= 1'b1;
                            cur_step  <= '0;
                            frequency <= freq_of(first_color);
                            led       <= led_of(first_color);
                            pre       <= '0;
                            ms        <= '0;
                        end
                    end
                    TONE: if (tone_end && last && !loop_on) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        frequency <= '0;
                        led       <= '0;
                    end else if (tone_end && gap != 16'd0) begin
                        state     <= GAP;
                        frequency <= '0;
                        led       <= '0;
                        pre       <= '0;
                        ms        <= '0;
                    end else if (tone_end) begin
                        cur_step  <= nxt;
                        frequency <= freq_of(mem[nxt]);
                        led       <= led_of(mem[nxt]);
                        pre       <= '0;
                        ms        <= '0;
                    end
                    GAP: if (gap_end) begin
                        state     <= TONE;
                        cur_step  <= nxt;
                        frequency <= freq_of(mem[nxt]);
                        led       <= led_of(mem[nxt]);
                        pre       <= '0;
                        ms        <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.frequency = frequency;
    assign bus.led       = led;
    assign bus.cur_step  = cur_step;
endmodule
